ps2_led_decoder: RTL and testbench
==================================

// Module: ps2_led_decoder
// PURPOSE
//  Next-generation LED controller. Consumes the PS/2 scan-code byte stream
//  (keyPressed strobe + keyDataOut byte) and decodes make/break/extended
//  prefixes. Filters to the 20 supported keys (A-J, 0-9), suppresses
//  typematic repeats, and keeps a short key history. Drives the red/green
//  LED banks in one of four selectable display modes. Sits between the PS/2
//  receiver and the board LEDs.
// PARAMETERS
//  RED_W      10  red LED count; must be >= 10
//  GREEN_W    8   green LED count; must be >= 4
//  BLINK_DIV  27  clock27 cycles per heartbeat half-period; must be >= 1
//  HIST_DEPTH 4   accepted-key history entries; must be >= 2
// PORTS
//  clock27     in   1        system clock; all logic on posedge
//  reset       in   1        synchronous, active-high reset
//  keyPressed  in   1        one-cycle strobe: keyDataOut holds a new byte
//  keyDataOut  in   8        PS/2 set-2 scan-code byte
//  mode        in   2        0 RAW, 1 ONEHOT, 2 COUNT, 3 HIST
//  clear       in   1        synchronous clear of key state (see BEHAVIOUR)
//  led_r       out  RED_W    red LED bank
//  led_g       out  GREEN_W  green LED bank
//  keyValid    out  1        one-cycle pulse on each accepted key
//  keyIndex    out  5        index of the last accepted key
// BEHAVIOUR
//  - Reset: led_r=0, led_g=0, keyValid=0, keyIndex=0. FSM=IDLE. Held, count,
//    history, lastCode and blink state all 0. No valid key exists after reset.
//  - Decoder FSM advances only on cycles with keyPressed=1:
//    - IDLE: E0->EXT; F0->BRK; recognised code->MAKE event; other->ignore.
//    - BRK: any byte->BREAK event for that byte, then IDLE.
//    - EXT: F0->EXTBRK; any other byte->ignored, IDLE.
//    - EXTBRK: any byte->ignored, IDLE.
//  - Key index map:
//    - 1C,32,21,23,24,2B,34,33,43,3B (A-J) -> 0..9.
//    - 16,1E,26,25,2E,36,3D,3E,46 (1-9) -> 10..18.
//    - 45 (0) -> 19.
//  - MAKE event:
//    - If a key is held and its index equals this one, the event is a repeat
//      and is dropped.
//    - Otherwise the key is accepted: lastCode, keyIndex and held are
//      updated, history shifts (entry 0 = newest), count increments.
//    - count is RED_W bits wide and wraps to 0.
//  - BREAK event: clears held only when the index matches the held index.
//    Unrecognised codes or a different index are ignored.
//  - Latency: a byte strobed at cycle n updates all outputs at n+1.
//    keyValid is high for exactly cycle n+1. All outputs are registered.
//  - led_r by mode (unused upper bits are 0):
//    - RAW: lastCode zero-extended.
//    - ONEHOT: bit (keyIndex mod 10) set; 0 if no valid key.
//    - COUNT: count.
//    - HIST: [4:0]=hist[0] index, [9:5]=hist[1] index; entries with no valid
//      key read as 0.
//    - A mode change is reflected at the next cycle.
//  - led_g:
//    - [0] = held.
//    - [1] = keyIndex>=10 (digit group).
//    - [2] = at least one key accepted since reset/clear.
//    - [GREEN_W-1] = heartbeat; toggles every BLINK_DIV cycles, free-running.
//    - All other bits 0.
//  - clear=1:
//    - Next cycle: held, count, history, lastCode, keyIndex and valid-key
//      state return to reset values; FSM returns to IDLE.
//    - Blink state is untouched.
//    - clear wins over a simultaneous keyPressed; that byte is dropped.
//  - reset mid-prefix (e.g. after F0) returns the FSM to IDLE. The next
//    byte is then decoded as a fresh code.
// TESTING
//  - Reset, then strobe 1C -> cycle+1: keyValid=1, keyIndex=0, led_r=0x01C,
//    led_g[0]=1, led_g[2]=1.
//  - mode=1; strobe 1C,1C,1C (typematic) then F0,1C -> exactly one keyValid
//    pulse, led_r=10'b1, led_g[0]=0 after the break.
//  - mode=1; strobe 45 -> keyIndex=19, led_r=10'b1000000000, led_g[1]=1.
//  - E0,1C then 5A -> no keyValid, FSM in IDLE. Then 32 -> keyIndex=1.
//  - mode=2; accept 1024 distinct alternating keys -> led_r wraps to 0.
//    clear with a simultaneous 24 strobe -> no keyValid, led_r=0, led_g[2]=0.
//  - mode=3; accept B then D -> led_r=10'b00001_00011.
//  - BLINK_DIV=3 -> led_g[7] toggles every 3 cycles through reset release.

Source files
------------

// File: rtl/ps2_led_decoder.sv
// PS/2 set-2 scan-code decoder for the 20 supported keys (A-J, 0-9) with
// typematic suppression, key history and four LED display modes.
module ps2_led_decoder #(
    parameter int RED_W      = 10,
    parameter int GREEN_W    = 8,
    parameter int BLINK_DIV  = 27,
    parameter int HIST_DEPTH = 4
) (
    input  logic               clock27,
    input  logic               reset,
    input  logic               keyPressed,
    input  logic [7:0]         keyDataOut,
    input  logic [1:0]         mode,
    input  logic               clear,
    output logic [RED_W-1:0]   led_r,
    output logic [GREEN_W-1:0] led_g,
    output logic               keyValid,
    output logic [4:0]         keyIndex
);

    localparam int            BCW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BCW-1:0] BLAST = BCW'(BLINK_DIV - 1);

    localparam logic [1:0] M_RAW    = 2'd0;
    localparam logic [1:0] M_ONEHOT = 2'd1;
    localparam logic [1:0] M_COUNT  = 2'd2;
    localparam logic [1:0] M_HIST   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXTBRK
    } state_t;

    // Returns {hit, index} for a make/break code.
    function automatic logic [5:0] key_lookup(input logic [7:0] code);
        logic [5:0] r;
        r = 6'd0;
        case (code)
            8'h1C: r = {1'b1, 5'd0};
            8'h32: r = {1'b1, 5'd1};
            8'h21: r = {1'b1, 5'd2};
            8'h23: r = {1'b1, 5'd3};
            8'h24: r = {1'b1, 5'd4};
            8'h2B: r = {1'b1, 5'd5};
            8'h34: r = {1'b1, 5'd6};
            8'h33: r = {1'b1, 5'd7};
            8'h43: r = {1'b1, 5'd8};
            8'h3B: r = {1'b1, 5'd9};
            8'h16: r = {1'b1, 5'd10};
            8'h1E: r = {1'b1, 5'd11};
            8'h26: r = {1'b1, 5'd12};
            8'h25: r = {1'b1, 5'd13};
            8'h2E: r = {1'b1, 5'd14};
            8'h36: r = {1'b1, 5'd15};
            8'h3D: r = {1'b1, 5'd16};
            8'h3E: r = {1'b1, 5'd17};
            8'h46: r = {1'b1, 5'd18};
            8'h45: r = {1'b1, 5'd19};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    state_t                          state_q, state_d;
    logic                            held_q, held_d;
    logic                            any_q, any_d;
    logic [4:0]                      idx_q, idx_d;
    logic [7:0]                      code_q, code_d;
    logic [RED_W-1:0]                cnt_q, cnt_d;
    logic [HIST_DEPTH-1:0][4:0]      hist_q, hist_d;
    logic [HIST_DEPTH-1:0]           histv_q, histv_d;
    logic                            valid_d;
    logic [BCW-1:0]                  bcnt_q, bcnt_d;
    logic                            blink_q, blink_d;
    logic [RED_W-1:0]                led_r_d;
    logic [GREEN_W-1:0]              led_g_d;

    logic       hit;
    logic [4:0] kidx;
    logic       is_repeat;
    logic [4:0] oh_pos;

    assign {hit, kidx} = key_lookup(keyDataOut);
    assign is_repeat   = held_q && (idx_q == kidx);

    // Decoder FSM and key state next-values.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        any_d   = any_q;
        idx_d   = idx_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        hist_d  = hist_q;
        histv_d = histv_q;
        valid_d = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            held_d  = 1'b0;
            any_d   = 1'b0;
            idx_d   = '0;
            code_d  = '0;
            cnt_d   = '0;
            hist_d  = '0;
            histv_d = '0;
        end else if (keyPressed) begin
            case (state_q)
                S_IDLE: begin
                    if (keyDataOut == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (keyDataOut == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (hit && !is_repeat) begin
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        any_d   = 1'b1;
                        idx_d   = kidx;
                        code_d  = keyDataOut;
                        cnt_d   = cnt_q + RED_W'(1);
                        for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                            hist_d[i]  = hist_q[i-1];
                            histv_d[i] = histv_q[i-1];
                        end
                        hist_d[0]  = kidx;
                        histv_d[0] = 1'b1;
                    end
                end
                S_BRK: begin
                    if (hit && is_repeat) held_d = 1'b0;
                    state_d = S_IDLE;
                end
                S_EXT:    state_d = (keyDataOut == 8'hF0) ? S_EXTBRK : S_IDLE;
                S_EXTBRK: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Free-running heartbeat; clear leaves it alone.
    always_comb begin
        bcnt_d  = bcnt_q + BCW'(1);
        blink_d = blink_q;
        if (bcnt_q == BLAST) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end
    end

    // Outputs are built from next-state values so they land one cycle after the strobe.
    always_comb begin
        oh_pos  = (idx_d >= 5'd10) ? idx_d - 5'd10 : idx_d;
        led_r_d = '0;
        case (mode)
            M_RAW:    led_r_d = RED_W'(code_d);
            M_ONEHOT: led_r_d = RED_W'(any_d) << oh_pos;
            M_COUNT:  led_r_d = cnt_d;
            M_HIST: begin
                led_r_d[4:0] = histv_d[0] ? hist_d[0] : 5'd0;
                led_r_d[9:5] = histv_d[1] ? hist_d[1] : 5'd0;
            end
            default:  led_r_d = '0;
        endcase
        led_g_d              = '0;
        led_g_d[0]           = held_d;
        led_g_d[1]           = idx_d >= 5'd10;
        led_g_d[2]           = any_d;
        led_g_d[GREEN_W-1]   = blink_d;
    end

    always_ff @(posedge clock27) begin
        if (reset) begin
            state_q  <= S_IDLE;
            held_q   <= 1'b0;
            any_q    <= 1'b0;
            idx_q    <= '0;
            code_q   <= '0;
            cnt_q    <= '0;
            hist_q   <= '0;
            histv_q  <= '0;
            bcnt_q   <= '0;
            blink_q  <= 1'b0;
            led_r    <= '0;
            led_g    <= '0;
            keyValid <= 1'b0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            any_q    <= any_d;
            idx_q    <= idx_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            hist_q   <= hist_d;
            histv_q  <= histv_d;
            bcnt_q   <= bcnt_d;
            blink_q  <= blink_d;
            led_r    <= led_r_d;
            led_g    <= led_g_d;
            keyValid <= valid_d;
        end
    end

    assign keyIndex = idx_q;

endmodule

// File: tb/tb_ps2_led_decoder.sv
// Bench for ps2_led_decoder: directed scenarios plus random byte streams
// checked against a queue-based behavioural model of the key decoder.
module tb_ps2_led_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       keyPressed = 1'b0;
    logic [7:0] keyDataOut = 8'h00;
    logic [1:0] mode = 2'd0;
    logic       clear = 1'b0;
    logic [9:0] led_r;
    logic [7:0] led_g;
    logic       keyValid;
    logic [4:0] keyIndex;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_led_decoder #(.RED_W(10), .GREEN_W(8), .BLINK_DIV(3), .HIST_DEPTH(4)) dut (
        .clock27(clk), .reset(reset), .keyPressed(keyPressed), .keyDataOut(keyDataOut),
        .mode(mode), .clear(clear), .led_r(led_r), .led_g(led_g),
        .keyValid(keyValid), .keyIndex(keyIndex)
    );

    always #5 clk = ~clk;

    // Edges since reset release drive the expected heartbeat.
    int edges = 0;
    always @(posedge clk) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    logic [7:0] keymap [20] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                                8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};

    // Behavioural model state
    bit         m_held, m_any, m_valid, m_e0, m_f0;
    int         m_idx, m_count;
    logic [7:0] m_code;
    int         m_hist[$];

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 20; i++) if (keymap[i] == b) return i;
        return -1;
    endfunction

    task automatic model_clear();
        m_held = 0; m_any = 0; m_valid = 0; m_e0 = 0; m_f0 = 0;
        m_idx = 0; m_count = 0; m_code = 8'h00;
        m_hist.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        k = lookup(b);
        m_valid = 0;
        if (m_e0 && m_f0) begin
            m_e0 = 0; m_f0 = 0;
        end else if (m_e0) begin
            if (b == 8'hF0) m_f0 = 1; else m_e0 = 0;
        end else if (m_f0) begin
            m_f0 = 0;
            if (k >= 0 && m_held && m_idx == k) m_held = 0;
        end else if (b == 8'hE0) begin
            m_e0 = 1;
        end else if (b == 8'hF0) begin
            m_f0 = 1;
        end else if (k >= 0 && !(m_held && m_idx == k)) begin
            m_valid = 1; m_held = 1; m_any = 1; m_idx = k; m_code = b;
            m_count = (m_count + 1) % 1024;
            m_hist.push_front(k);
            if (m_hist.size() > 4) void'(m_hist.pop_back());
        end
    endtask

    function automatic logic [9:0] exp_r();
        logic [9:0] r;
        r = 10'd0;
        case (mode)
            2'd0: r = {2'b00, m_code};
            2'd1: r = m_any ? (10'd1 << (m_idx % 10)) : 10'd0;
            2'd2: r = 10'(m_count);
            default: begin
                if (m_hist.size() > 0) r[4:0] = 5'(m_hist[0]);
                if (m_hist.size() > 1) r[9:5] = 5'(m_hist[1]);
            end
        endcase
        return r;
    endfunction

    function automatic logic [7:0] exp_g();
        logic [7:0] g;
        g = 8'd0;
        g[0] = m_held;
        g[1] = (m_idx >= 10);
        g[2] = m_any;
        g[7] = ((edges / 3) % 2) == 1;
        return g;
    endfunction

    // Presents one cycle of input at a negedge, returns at the next negedge.
    task automatic drive(input logic [7:0] b, input bit kp, input bit clr);
        keyPressed = kp; keyDataOut = b; clear = clr;
        if (clr)     model_clear();
        else if (kp) model_byte(b);
        else         m_valid = 0;
        @(negedge clk);
        keyPressed = 0; clear = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        model_clear();
        @(negedge clk); @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        if (led_r !== 10'd0) begin n_bad++; $display("FAIL reset_led_r got %h want 000", led_r); end
        n_cmp++;
        if (led_g !== 8'd0) begin n_bad++; $display("FAIL reset_led_g got %h want 00", led_g); end
        n_cmp++;
        if (keyValid !== 1'b0) begin n_bad++; $display("FAIL reset_keyValid got %b want 0", keyValid); end
        n_cmp++;
        if (keyIndex !== 5'd0) begin n_bad++; $display("FAIL reset_keyIndex got %0d want 0", keyIndex); end
        n_cmp++;
    endtask

    task automatic test_first_key();
        mode = 2'd0;
        drive(8'h1C, 1, 0);
        if (keyValid !== 1'b1) begin n_bad++; $display("FAIL first_valid got %b want 1", keyValid); end
        n_cmp++;
        if (keyIndex !== 5'd0) begin n_bad++; $display("FAIL first_index got %0d want 0", keyIndex); end
        n_cmp++;
        if (led_r !== 10'h01C) begin n_bad++; $display("FAIL first_led_r got %h want 01c", led_r); end
        n_cmp++;
        if (led_g[2:0] !== 3'b101) begin n_bad++; $display("FAIL first_led_g got %b want 101", led_g[2:0]); end
        n_cmp++;
        drive(8'h00, 0, 0);
        if (keyValid !== 1'b0) begin n_bad++; $display("FAIL first_pulse_width got %b want 0", keyValid); end
        n_cmp++;
    endtask

    task automatic test_typematic();
        logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        int pulses = 0;
        do_reset();
        mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            drive(seq[i], 1, 0);
            if (keyValid === 1'b1) pulses++;
        end
        if (pulses != 1) begin n_bad++; $display("FAIL typematic_pulses got %0d want 1", pulses); end
        n_cmp++;
        if (led_r !== 10'b1) begin n_bad++; $display("FAIL typematic_led_r got %b want 0000000001", led_r); end
        n_cmp++;
        if (led_g[0] !== 1'b0) begin n_bad++; $display("FAIL typematic_held got %b want 0", led_g[0]); end
        n_cmp++;
    endtask

    task automatic test_digit();
        mode = 2'd1;
        drive(8'h45, 1, 0);
        if (keyIndex !== 5'd19) begin n_bad++; $display("FAIL digit_index got %0d want 19", keyIndex); end
        n_cmp++;
        if (led_r !== 10'b1000000000) begin n_bad++; $display("FAIL digit_led_r got %b want 1000000000", led_r); end
        n_cmp++;
        if (led_g[1] !== 1'b1) begin n_bad++; $display("FAIL digit_group got %b want 1", led_g[1]); end
        n_cmp++;
    endtask

    task automatic test_extended();
        logic [7:0] seq [3] = '{8'hE0, 8'h1C, 8'h5A};
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            drive(seq[i], 1, 0);
            if (keyValid === 1'b1) pulses++;
        end
        if (pulses != 0) begin n_bad++; $display("FAIL ext_pulses got %0d want 0", pulses); end
        n_cmp++;
        drive(8'h32, 1, 0);
        if (keyValid !== 1'b1 || keyIndex !== 5'd1) begin
            n_bad++; $display("FAIL ext_then_b got valid=%b idx=%0d want valid=1 idx=1", keyValid, keyIndex);
        end
        n_cmp++;
    endtask

    task automatic test_wrap_and_clear();
        do_reset();
        mode = 2'd2;
        for (int i = 0; i < 1024; i++) begin
            drive((i % 2 == 0) ? 8'h1C : 8'h32, 1, 0);
            if (i == 1022) begin
                if (led_r !== 10'd1023) begin n_bad++; $display("FAIL wrap_pre got %0d want 1023", led_r); end
                n_cmp++;
            end
        end
        if (led_r !== 10'd0) begin n_bad++; $display("FAIL wrap_zero got %0d want 0", led_r); end
        n_cmp++;
        if (led_g[2] !== 1'b1) begin n_bad++; $display("FAIL wrap_any got %b want 1", led_g[2]); end
        n_cmp++;
        drive(8'h24, 1, 1);
        if (keyValid !== 1'b0 || led_r !== 10'd0 || led_g[2] !== 1'b0 || keyIndex !== 5'd0) begin
            n_bad++;
            $display("FAIL clear_wins got valid=%b led_r=%0d any=%b idx=%0d want 0 0 0 0",
                     keyValid, led_r, led_g[2], keyIndex);
        end
        n_cmp++;
    endtask

    task automatic test_history();
        do_reset();
        mode = 2'd3;
        drive(8'h32, 1, 0);
        drive(8'h23, 1, 0);
        if (led_r !== 10'b00001_00011) begin n_bad++; $display("FAIL hist_led_r got %b want 0000100011", led_r); end
        n_cmp++;
    endtask

    task automatic test_reset_mid_prefix();
        mode = 2'd0;
        drive(8'h21, 1, 0);
        drive(8'hF0, 1, 0);
        do_reset();
        drive(8'h21, 1, 0);
        if (keyValid !== 1'b1 || led_r !== 10'h021) begin
            n_bad++; $display("FAIL mid_prefix got valid=%b led_r=%h want 1 021", keyValid, led_r);
        end
        n_cmp++;
    endtask

    task automatic test_blink();
        reset = 1;
        model_clear();
        @(negedge clk); @(negedge clk);
        if (led_g[7] !== 1'b0) begin n_bad++; $display("FAIL blink_in_reset got %b want 0", led_g[7]); end
        n_cmp++;
        reset = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (led_g[7] !== (((k / 3) % 2) == 1)) begin
                n_bad++; $display("FAIL blink_k%0d got %b want %b", k, led_g[7], ((k / 3) % 2) == 1);
            end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         kp, clr;
        int         sel;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel < 5)       b = keymap[$urandom_range(0, 4) + ((sel == 0) ? 15 : 0)];
            else if (sel == 5) b = 8'hE0;
            else if (sel < 8)  b = 8'hF0;
            else               b = 8'($urandom);
            kp  = ($urandom_range(0, 5) != 0);
            clr = ($urandom_range(0, 40) == 0);
            drive(b, kp, clr);
            if (keyValid !== m_valid || keyIndex !== 5'(m_idx) || led_r !== exp_r() || led_g !== exp_g()) begin
                n_bad++;
                $display("FAIL random_%0d got v=%b i=%0d r=%h g=%h want v=%b i=%0d r=%h g=%h", i,
                         keyValid, keyIndex, led_r, led_g, m_valid, m_idx, exp_r(), exp_g());
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_first_key();
        test_typematic();
        test_digit();
        test_extended();
        test_wrap_and_clear();
        test_history();
        test_reset_mid_prefix();
        test_blink();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
